// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types for the FIFO family.
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: register array with one synchronous write port and an asynchronous read port.
module sync_fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);
  logic [DSIZE-1:0] mem [1<<ASIZE];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with STD/FWFT read modes, thresholds, fill count, flush and sticky errors.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int         DSIZE    = 8,
  parameter int         ASIZE    = 4,
  parameter fifo_mode_e MODE     = FIFO_STD,
  parameter int         AF_LEVEL = (1 << ASIZE) - 2,
  parameter int         AE_LEVEL = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  output logic             wfull,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic [ASIZE:0]   wcount,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);
  localparam int DEPTH = 1 << ASIZE;
  if (ASIZE < 1 || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_params
    $error("sync_fifo: illegal ASIZE/AE_LEVEL/AF_LEVEL");
  end
  localparam logic [ASIZE:0] AF = AF_LEVEL[ASIZE:0];
  localparam logic [ASIZE:0] AE = AE_LEVEL[ASIZE:0];
  logic [ASIZE:0] wptr, rptr;
  logic [DSIZE-1:0] head, rdata_q;
  logic we, re;
  assign we = winc && !wfull && !flush;
  assign re = rinc && !rempty && !flush;
  // extra pointer MSB distinguishes full from empty when the address bits match
  assign rempty = wptr == rptr;
  assign wfull = (wptr[ASIZE] != rptr[ASIZE]) && (wptr[ASIZE-1:0] == rptr[ASIZE-1:0]);
  assign wcount = wptr - rptr;
  assign almost_full = wcount >= AF;
  assign almost_empty = wcount <= AE;
  assign rdata = MODE == FIFO_FWFT ? head : rdata_q;
  sync_fifo_mem #(.DSIZE(DSIZE), .ASIZE(ASIZE)) u_mem (
    .clk(clk),
    .we(we),
    .waddr(wptr[ASIZE-1:0]),
    .wdata(wdata),
    .raddr(rptr[ASIZE-1:0]),
    .rdata(head)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      rdata_q <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      rdata_q <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (we) wptr <= wptr + 1'b1;
      if (re) rptr <= rptr + 1'b1;
      if (re && MODE == FIFO_STD) rdata_q <= head;
      if (winc && wfull) overflow <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed vector table plus hand-written corner sequences for STD and FWFT builds.
module tb_sync_fifo;
  import fifo_pkg::*;
  logic clk = 0, rst_n = 0;
  logic flush = 0, winc = 0, rinc = 0;
  logic [7:0] wdata = 0, rdata;
  logic wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] wcount;
  logic f_winc = 0, f_rinc = 0;
  logic [7:0] f_wdata = 0, f_rdata;
  logic f_wfull, f_rempty, f_af, f_ae, f_ov, f_un;
  logic [4:0] f_wcount;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DSIZE(8), .ASIZE(4), .MODE(FIFO_STD), .AF_LEVEL(14), .AE_LEVEL(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .winc(winc), .wdata(wdata), .wfull(wfull),
    .rinc(rinc), .rdata(rdata), .rempty(rempty), .wcount(wcount), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow));

  sync_fifo #(.DSIZE(8), .ASIZE(4), .MODE(FIFO_FWFT), .AF_LEVEL(14), .AE_LEVEL(2)) dut_f (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .winc(f_winc), .wdata(f_wdata), .wfull(f_wfull),
    .rinc(f_rinc), .rdata(f_rdata), .rempty(f_rempty), .wcount(f_wcount), .almost_full(f_af),
    .almost_empty(f_ae), .overflow(f_ov), .underflow(f_un));

  typedef struct {
    logic w, r, f;
    logic [7:0] d;
    int cnt;
    logic e, fu, af, ae, ov, un;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cnt, input logic e, input logic fu,
                         input logic af, input logic ae, input logic ov, input logic un, input logic [7:0] rd);
    chk({tag, ".wcount"}, int'(wcount), cnt);
    chk({tag, ".rempty"}, int'(rempty), int'(e));
    chk({tag, ".wfull"}, int'(wfull), int'(fu));
    chk({tag, ".almost_full"}, int'(almost_full), int'(af));
    chk({tag, ".almost_empty"}, int'(almost_empty), int'(ae));
    chk({tag, ".overflow"}, int'(overflow), int'(ov));
    chk({tag, ".underflow"}, int'(underflow), int'(un));
    chk({tag, ".rdata"}, int'(rdata), int'(rd));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    int toggles;
    logic last_msb;
    //          w  r  f  d      cnt e  fu af ae ov un rd
    tbl[0] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'h00};
    tbl[1] = '{1, 0, 0, 8'hA5, 1, 0, 0, 0, 1, 0, 0, 8'h00};
    tbl[2] = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 0, 8'hA5};
    tbl[3] = '{0, 1, 0, 8'h00, 0, 1, 0, 0, 1, 0, 1, 8'hA5};
    tbl[4] = '{1, 1, 0, 8'h11, 1, 0, 0, 0, 1, 0, 1, 8'hA5};
    tbl[5] = '{1, 0, 1, 8'h22, 0, 1, 0, 0, 1, 0, 0, 8'h00};
    #12;
    chk_all("reset", 0, 1, 0, 0, 1, 0, 0, 8'h00);
    rst_n = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      winc = tbl[i].w; rinc = tbl[i].r; flush = tbl[i].f; wdata = tbl[i].d;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].e, tbl[i].fu, tbl[i].af,
              tbl[i].ae, tbl[i].ov, tbl[i].un, tbl[i].rd);
    end
    winc = 0; rinc = 0; flush = 0;
    for (int i = 0; i < 16; i++) begin
      winc = 1; wdata = 8'(i);
      tick();
      chk($sformatf("fill%0d.wcount", i), int'(wcount), i + 1);
      chk($sformatf("fill%0d.af", i), int'(almost_full), int'(i + 1 >= 14));
      chk($sformatf("fill%0d.full", i), int'(wfull), int'(i == 15));
    end
    wdata = 8'hFF;
    tick();
    chk("over.wcount", int'(wcount), 16);
    chk("over.flag", int'(overflow), 1);
    winc = 1; rinc = 1; wdata = 8'hEE;
    tick();
    chk("fullrw.wcount", int'(wcount), 15);
    chk("fullrw.ovf", int'(overflow), 1);
    chk("fullrw.rdata", int'(rdata), 8'h00);
    winc = 0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk($sformatf("drain%0d.rdata", i), int'(rdata), i);
    end
    rinc = 0;
    tick();
    chk_all("drained", 0, 1, 0, 0, 1, 1, 0, 8'h0F);
    toggles = 0;
    last_msb = dut.wptr[4];
    winc = 1; wdata = 8'h40; q.push_back(8'h40);
    tick();
    rinc = 1;
    for (int i = 1; i < 41; i++) begin
      winc = i < 40;
      wdata = 8'(8'h40 + i);
      if (winc) q.push_back(wdata);
      exp_d = q.pop_front();
      tick();
      chk($sformatf("wrap%0d.rdata", i), int'(rdata), int'(exp_d));
      chk($sformatf("wrap%0d.wcount", i), int'(wcount), i < 40 ? 1 : 0);
      if (dut.wptr[4] != last_msb) toggles++;
      last_msb = dut.wptr[4];
    end
    winc = 0; rinc = 0;
    chk("wrap.msb_toggles", int'(toggles >= 2), 1);
    rinc = 1;
    tick();
    rinc = 0;
    for (int i = 0; i < 9; i++) begin
      winc = 1; wdata = 8'(8'h80 + i);
      tick();
    end
    chk("pre_flush.wcount", int'(wcount), 9);
    chk("pre_flush.underflow", int'(underflow), 1);
    flush = 1; wdata = 8'h99;
    tick();
    flush = 0; winc = 0;
    chk_all("flush", 0, 1, 0, 0, 1, 0, 0, 8'h00);
    winc = 1; wdata = 8'h55;
    tick();
    tick();
    winc = 0; rinc = 1;
    tick();
    rinc = 1;
    chk("burst.rdata", int'(rdata), 8'h55);
    rst_n = 0;
    #2;
    chk_all("async_rst", 0, 1, 0, 0, 1, 0, 0, 8'h00);
    rinc = 0;
    #5 rst_n = 1;
    tick();
    chk_all("post_rst", 0, 1, 0, 0, 1, 0, 0, 8'h00);
    f_winc = 1; f_wdata = 8'h3C;
    tick();
    f_wdata = 8'h5A;
    tick();
    f_winc = 0;
    chk("fwft.rdata", int'(f_rdata), 8'h3C);
    chk("fwft.rempty", int'(f_rempty), 0);
    chk("fwft.wcount", int'(f_wcount), 2);
    f_rinc = 1;
    tick();
    f_rinc = 0;
    chk("fwft.pop_rdata", int'(f_rdata), 8'h5A);
    chk("fwft.pop_wcount", int'(f_wcount), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO: the next-generation buffer alongside the dual-clock `beh_fifo`, for paths where producer and consumer share one clock. It adds configurable depth, standard or first-word-fall-through read mode, programmable almost-full and almost-empty thresholds, a fill count, synchronous flush and sticky overflow/underflow error flags. Handshake names follow the existing FIFO interfaces so the `fifo_wif`/`fifo_rif` style benches can drive it.

## Interface
- `DSIZE`, 8: data width in bits.
- `ASIZE`, 4: address width; DEPTH = 2**ASIZE.
- `MODE`, FIFO_STD: `fifo_mode_e`; FIFO_STD gives a registered read, FIFO_FWFT gives first-word-fall-through.
- `AF_LEVEL`, DEPTH-2: `almost_full` asserts when `wcount >= AF_LEVEL`.
- `AE_LEVEL`, 2: `almost_empty` asserts when `wcount <= AE_LEVEL`.
- Ports:
  - `clk`  in  1  sole clock, rising edge.
  - `rst_n`  in  1  asynchronous, active-low reset.
  - `flush`  in  1  synchronous empty command.
  - `winc`  in  1  write request.
  - `wdata`  in  DSIZE  write data.
  - `wfull`  out  1  FIFO full.
  - `rinc`  in  1  read request (pop).
  - `rdata`  out  DSIZE  read data.
  - `rempty`  out  1  FIFO empty.
  - `wcount`  out  ASIZE+1  words stored, 0..DEPTH.
  - `almost_full`  out  1  threshold flag.
  - `almost_empty`  out  1  threshold flag.
  - `overflow`  out  1  sticky; a write was attempted while full.
  - `underflow`  out  1  sticky; a read was attempted while empty.

## Operation
- Parameter legality, checked at elaboration: ASIZE >= 1 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH.
- Pointers are ASIZE+1 bits. The low ASIZE bits address the memory and wrap naturally. Full is detected when the MSBs differ and the low bits are equal.
- A write is accepted iff `winc && !wfull`; the word is stored at the write pointer and the pointer increments.
- A read is accepted iff `rinc && !rempty`; the read pointer increments.
- Simultaneous accepted read and write: `wcount` is unchanged and both pointers advance.
- When full, with `winc` and `rinc` both high: only the read is accepted and the write is dropped, which sets `overflow`.
- When empty, with `winc` and `rinc` both high: only the write is accepted and the read is ignored, which sets `underflow`.
- FIFO_STD: on an accepted read, `rdata` loads the head word at the next edge. Otherwise `rdata` holds its value.
- FIFO_FWFT: `rdata` continuously shows the head word whenever `!rempty`. `rinc` pops that word. `rdata` is don't-care while empty.
- `flush` has priority over `winc` and `rinc` in the same cycle. At the next edge it sets pointers and `wcount` to 0 and clears `overflow`/`underflow`. In FIFO_STD it also sets `rdata` to 0. Memory contents are not cleared.
- `overflow`/`underflow` stay set until `flush` or reset.

## Timing
- Reset values: `rempty`=1, `almost_empty`=1, `wfull`=0, `almost_full`=0, `wcount`=0, `rdata`=0, `overflow`=0, `underflow`=0.
- All flags decode registered state only; no output has a combinational path from `winc`, `rinc` or `flush`.
- Write accepted at edge n: `wcount`, `rempty`, `wfull` and the thresholds update after edge n. In FWFT mode the word is on `rdata` in cycle n+1.
- FIFO_STD read accepted at edge n: data is on `rdata` after edge n (one cycle of latency).
- Sustained one read plus one write per cycle is supported at any fill level from 1 to DEPTH-1.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge. After deassertion the FIFO is empty.

## Structure
- `fifo_pkg`: add `typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;`.
- Sub-module `sync_fifo_mem`: DEPTH x DSIZE register array with one synchronous write port and an asynchronous read address. It has no reset.
- `sync_fifo` holds the pointers, count, flags and the STD-mode output register.

## Test plan
All scenarios use DSIZE=8, ASIZE=4, AF_LEVEL=14, AE_LEVEL=2.
- Reset then idle: `rempty`=1, `almost_empty`=1, `wcount`=0, `rdata`=0x00. Write 0xA5, then read in STD mode: `rdata`=0xA5 one cycle after the `rinc` edge.
- Write 0x00..0x0F: `almost_full` rises at `wcount`=14 and `wfull` at 16. A 17th write (0xFF) sets `overflow`. Read all 16: the data sequence is 0x00..0x0F and 0xFF never appears.
- Wrap-around: 40 writes interleaved with 40 reads, keeping fill between 1 and 15. Data arrives in order and both pointer MSBs toggle at least twice.
- Simultaneous `winc`+`rinc` while full and while empty: full gives `wcount` 16→15 with `overflow`=1; empty gives `wcount` 0→1 with `underflow`=1.
- FWFT build: write 0x3C; the next cycle shows `rdata`=0x3C and `rempty`=0 with no `rinc` applied.
- With 9 words stored, raise `flush` together with `winc`. Next cycle: `wcount`=0, `rempty`=1, sticky flags clear. Pulse `rst_n` low mid-burst: outputs return to reset values without a clock edge.
